vga_sync_gen: RTL and testbench

// Raster timing generator for the VGA path. Runs in the pixel-clock domain from
// the PLL and counts pixels and lines. Produces registered hsync/vsync, an

---
 rtl/vga_sync_gen.sv | 111 +++++++++++
 tb/tb_vga_sync_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - raster timing generator with registered sync, active, coordinates and strobes
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_NEG = 1'b1,
    parameter int CW       = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode boundaries as CW-bit constants so every compare is same-width unsigned.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Counter advance and output decode from the current (hc,vc); everything holds while stalled.
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            x_d           = hc_q;
            y_d           = vc_q;
            active_d      = (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
            // XOR with SYNC_NEG maps "in pulse" to the configured asserted level.
            hsync_d       = ((hc_q >= H_SYNC_BEG) && (hc_q < H_SYNC_END)) ^ SYNC_NEG;
            vsync_d       = ((vc_q >= V_SYNC_BEG) && (vc_q < V_SYNC_END)) ^ SYNC_NEG;
            line_start_d  = (hc_q == '0);
            frame_start_d = (hc_q == '0) && (vc_q == '0);
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    // State and output registers; reset parks syncs at their deasserted level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= SYNC_NEG;
            vsync_q       <= SYNC_NEG;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (default and small timings)
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int   run;
        bit   en;
        obs_t exp;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_a, en_a, rst_b, en_b;
    logic       a_hs, a_vs, a_act, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_act, b_ls, b_fs;
    logic [9:0] b_x, b_y;

    int n_tests = 0;
    int n_fail  = 0;

    vga_sync_gen dut_a (
        .clock(clock), .reset(rst_a), .enable(en_a),
        .hsync(a_hs), .vsync(a_vs), .active(a_act), .x(a_x), .y(a_y),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_NEG(1'b0), .CW(10)
    ) dut_b (
        .clock(clock), .reset(rst_b), .enable(en_b),
        .hsync(b_hs), .vsync(b_vs), .active(b_act), .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs)
    );

    obs_t obs_a, obs_b;
    assign obs_a = '{x: a_x, y: a_y, act: a_act, hs: a_hs, vs: a_vs, ls: a_ls, fs: a_fs};
    assign obs_b = '{x: b_x, y: b_y, act: b_act, hs: b_hs, vs: b_vs, ls: b_ls, fs: b_fs};

    function automatic obs_t mk(int xx, int yy, bit act, bit hs, bit vs, bit ls, bit fs);
        obs_t o;
        o.x = 10'(xx); o.y = 10'(yy);
        o.act = act; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    // What the outputs show for the p-th enabled pixel since reset, from raster arithmetic.
    function automatic obs_t model_pix(int p, int ha, int hf, int hsw, int hb,
                                       int va, int vf, int vsw, int vb, bit neg);
        int ht, vt, h, v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        h  = p % ht;
        v  = (p / ht) % vt;
        return mk(h, v, (h < ha) && (v < va),
                  ((h >= ha + hf) && (h < ha + hf + hsw)) ^ neg,
                  ((v >= va + vf) && (v < va + vf + vsw)) ^ neg,
                  h == 0, (h == 0) && (v == 0));
    endfunction

    int   pa, pb;
    obs_t ea, eb;

    task automatic cmp(string nm, obs_t got, obs_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b, want x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b",
                     nm, got.x, got.y, got.act, got.hs, got.vs, got.ls, got.fs,
                     exp.x, exp.y, exp.act, exp.hs, exp.vs, exp.ls, exp.fs);
        end
    endtask

    task automatic cmp_int(string nm, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, exp);
        end
    endtask

    task automatic step_a(bit e);
        en_a = e;
        @(posedge clock);
        #1;
        if (e) begin
            ea = model_pix(pa, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
            pa++;
        end else begin
            ea.ls = 1'b0;
            ea.fs = 1'b0;
        end
    endtask

    task automatic step_b(bit e);
        en_b = e;
        @(posedge clock);
        #1;
        if (e) begin
            eb = model_pix(pb, 8, 2, 3, 1, 4, 1, 1, 1, 1'b0);
            pb++;
        end else begin
            eb.ls = 1'b0;
            eb.fs = 1'b0;
        end
    endtask

    vec_t tbl[14];

    initial begin
        int last_ls, hs_cnt, act_cnt, guard;

        tbl[0]  = '{1,  1'b1, mk(0,  0, 1, 0, 0, 1, 1)};
        tbl[1]  = '{1,  1'b0, mk(0,  0, 1, 0, 0, 0, 0)};
        tbl[2]  = '{7,  1'b1, mk(7,  0, 1, 0, 0, 0, 0)};
        tbl[3]  = '{1,  1'b1, mk(8,  0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{2,  1'b1, mk(10, 0, 0, 1, 0, 0, 0)};
        tbl[5]  = '{2,  1'b1, mk(12, 0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{1,  1'b1, mk(13, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1,  1'b1, mk(0,  1, 1, 0, 0, 1, 0)};
        tbl[8]  = '{3,  1'b0, mk(0,  1, 1, 0, 0, 0, 0)};
        tbl[9]  = '{56, 1'b1, mk(0,  5, 0, 0, 1, 1, 0)};
        tbl[10] = '{13, 1'b1, mk(13, 5, 0, 0, 1, 0, 0)};
        tbl[11] = '{1,  1'b1, mk(0,  6, 0, 0, 0, 1, 0)};
        tbl[12] = '{13, 1'b1, mk(13, 6, 0, 0, 0, 0, 0)};
        tbl[13] = '{1,  1'b1, mk(0,  0, 1, 0, 0, 1, 1)};

        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        ea = mk(0, 0, 0, 1, 1, 0, 0); pa = 0;
        eb = mk(0, 0, 0, 0, 0, 0, 0); pb = 0;
        cmp("reset_a", obs_a, ea);
        cmp("reset_b", obs_b, eb);
        rst_a = 1'b0; rst_b = 1'b0;

        // Small timing: hand-computed table across hsync, vsync and frame wrap.
        foreach (tbl[i]) begin
            repeat (tbl[i].run) step_b(tbl[i].en);
            cmp($sformatf("table_%0d", i), obs_b, tbl[i].exp);
        end

        // Small timing: random stalls over several frames against the model.
        for (int i = 0; i < 700; i++) begin
            step_b(($urandom % 4) != 0);
            cmp("rand_b", obs_b, eb);
        end

        // Small timing: reset mid-frame at x=5,y=2.
        guard = 0;
        while (!(eb.x == 10'd5 && eb.y == 10'd2 && eb.ls == 1'b0) && guard < 300) begin
            step_b(1'b1);
            guard++;
        end
        cmp_int("reach_x5y2", guard < 300, 1);
        rst_b = 1'b1;
        #1;
        eb = mk(0, 0, 0, 0, 0, 0, 0); pb = 0;
        cmp("async_reset_b", obs_b, eb);
        en_b = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        cmp("held_reset_b", obs_b, eb);
        rst_b = 1'b0;
        step_b(1'b1);
        cmp("first_after_reset_b", obs_b, mk(0, 0, 1, 0, 0, 1, 1));
        step_b(1'b1);
        cmp("second_after_reset_b", obs_b, eb);
        en_b = 1'b0;

        // Default timing: two lines plus, with line_start period and hsync/active widths.
        last_ls = -1; hs_cnt = 0; act_cnt = 0;
        for (int c = 0; c < 1700; c++) begin
            step_a(1'b1);
            cmp("run_a", obs_a, ea);
            if (a_ls) begin
                if (last_ls >= 0) cmp_int("line_period", c - last_ls, 800);
                last_ls = c;
            end
            if (a_y == 10'd0 && a_hs == 1'b0) hs_cnt++;
            if (a_y == 10'd0 && a_act) act_cnt++;
        end
        cmp_int("hsync_width", hs_cnt, 96);
        cmp_int("active_width", act_cnt, 640);

        // Default timing: random stalls, then async reset mid-line.
        for (int i = 0; i < 300; i++) begin
            step_a(($urandom % 3) != 0);
            cmp("rand_a", obs_a, ea);
        end
        rst_a = 1'b1;
        #1;
        ea = mk(0, 0, 0, 1, 1, 0, 0); pa = 0;
        cmp("async_reset_a", obs_a, ea);
        repeat (3) @(posedge clock);
        #1;
        rst_a = 1'b0;
        step_a(1'b0);
        cmp("stalled_after_reset_a", obs_a, ea);
        step_a(1'b1);
        cmp("first_after_reset_a", obs_a, mk(0, 0, 1, 1, 1, 1, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
